// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, byte helper, ShiftRows index map and
// the FSM encoding used by the serial SubBytes stage.
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = AES_STATE_W / 8;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_BUSY,
    SB_DONE
  } sb_fsm_e;

  // Output byte i of ShiftRows takes input byte SHIFT_ROWS_MAP[i]
  // (byte index = row + 4*column, row r rotated left by r).
  localparam int unsigned SHIFT_ROWS_MAP [AES_NUM_BYTES] = '{
    0, 5, 10, 15,
    4, 9, 14,  3,
    8, 13, 2,  7,
    12, 1, 6, 11
  };

  // Byte 0 is the most significant byte of the state.
  function automatic logic [7:0] get_byte(input aes_state_t state, input int unsigned idx);
    return state[AES_STATE_W-1-8*idx -: 8];
  endfunction

endpackage

// File: rtl/sub_bytes_serial_sbox.sv
// Forward AES S-box: purely combinational 256-entry lookup of one byte.
module forward_substitution_box (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX_TABLE[(255 - int'(i_byte)) * 8 +: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// Iterative AES-128 SubBytes: BYTES_PER_CYCLE S-boxes walk the state over
// NUM_STEPS cycles. Define SUB_BYTES_FUSE_SHIFT_ROWS_EN to fold ShiftRows into out_state.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
    $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  sb_fsm_e          r_fsm;
  sb_fsm_e          w_fsm_nxt;
  logic [CNT_W-1:0] r_cnt;
  aes_state_t       r_work;
  aes_state_t       w_work_sub;
  logic             w_load;
  logic             w_step;
  logic [7:0]       w_sbox_in  [BYTES_PER_CYCLE];
  logic [7:0]       w_sbox_out [BYTES_PER_CYCLE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= SB_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    case (r_fsm)
      SB_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load    = 1'b1;
          w_fsm_nxt = SB_BUSY;
        end
      end
      SB_BUSY: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) w_fsm_nxt = SB_DONE;
      end
      SB_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_load    = 1'b1;
            w_fsm_nxt = SB_BUSY;
          end else begin
            w_fsm_nxt = SB_IDLE;
          end
        end
      end
      default: w_fsm_nxt = SB_IDLE;
    endcase
  end

  // The step counter selects which slice of the working register feeds the S-boxes.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign w_sbox_in[j] = get_byte(r_work, int'(r_cnt) * BYTES_PER_CYCLE + j);
    forward_substitution_box u_sbox (
      .i_byte (w_sbox_in[j]),
      .o_byte (w_sbox_out[j])
    );
  end

  always_comb begin
    w_work_sub = r_work;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      w_work_sub[AES_STATE_W-1-8*(int'(r_cnt) * BYTES_PER_CYCLE + j) -: 8] = w_sbox_out[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_work <= in_state;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_work <= w_work_sub;
      r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

`ifdef SUB_BYTES_FUSE_SHIFT_ROWS_EN
  always_comb begin
    out_state = '0;
    for (int i = 0; i < AES_NUM_BYTES; i++) begin
      out_state[AES_STATE_W-1-8*i -: 8] = get_byte(r_work, SHIFT_ROWS_MAP[i]);
    end
  end
`else
  assign out_state = r_work;
`endif

endmodule
